// File: rtl/writeback_arbiter_pkg.sv
// writeback_arbiter_pkg: register file geometry shared by the write-back slice
package writeback_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam int NUM_REGS = 32;
endpackage

// File: rtl/writeback_arbiter_wb_fifo.sv
// wb_fifo: in-order {addr,data} queue with count, pointers and per-entry valids exported for forwarding
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CW-1:0]     count,
  output logic [PW-1:0]     rd_ptr,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [DEPTH-1:0]  ent_valid,
  output logic [ADDR_W-1:0] ent_addr [DEPTH],
  output logic [DATA_W-1:0] ent_data [DEPTH]
);
  logic [PW-1:0] wr_ptr;
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      ent_valid <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        ent_valid[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        ent_valid[wr_ptr] <= 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clock) begin
    if (push) begin
      ent_addr[wr_ptr] <= push_addr;
      ent_data[wr_ptr] <= push_data;
    end
  end
  assign head_addr = ent_addr[rd_ptr];
  assign head_data = ent_data[rd_ptr];
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges mem/alu results into a queue draining one register write per cycle, with two forwarding ports
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              rf_hold,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_writeaddr,
  output logic [DATA_W-1:0] rf_writedata,
  input  logic [ADDR_W-1:0] fwd_addr1,
  output logic              fwd_hit1,
  output logic [DATA_W-1:0] fwd_data1,
  input  logic [ADDR_W-1:0] fwd_addr2,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data2,
  output logic [CW-1:0]     wb_count
);
  logic push, mem_fire, alu_fire;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;
  logic [PW-1:0] rd_ptr;
  logic [DEPTH-1:0] ent_valid;
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  assign rf_write = (wb_count != '0) & ~rf_hold & ~reset;
  assign mem_ready = ~reset & ((wb_count != CW'(DEPTH)) | rf_write);
  assign alu_ready = mem_ready & ~mem_valid;
  assign mem_fire = mem_valid & mem_ready;
  assign alu_fire = alu_valid & alu_ready;
  assign push_addr = mem_fire ? mem_addr : alu_addr;
  assign push_data = mem_fire ? mem_data : alu_data;
  assign push = (mem_fire | alu_fire) & (push_addr != ADDR_W'(REG_ZERO));
  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .push_addr(push_addr),
    .push_data(push_data),
    .pop(rf_write),
    .count(wb_count),
    .rd_ptr(rd_ptr),
    .head_addr(rf_writeaddr),
    .head_data(rf_writedata),
    .ent_valid(ent_valid),
    .ent_addr(ent_addr),
    .ent_data(ent_data)
  );
  always_comb begin
    logic [PW-1:0] idx;
    idx = '0;
    fwd_hit1 = 1'b0;
    fwd_data1 = '0;
    fwd_hit2 = 1'b0;
    fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (ent_valid[idx] && ent_addr[idx] == fwd_addr1 && fwd_addr1 != ADDR_W'(REG_ZERO)) begin
        fwd_hit1 = 1'b1;
        fwd_data1 = ent_data[idx];
      end
      if (ent_valid[idx] && ent_addr[idx] == fwd_addr2 && fwd_addr2 != ADDR_W'(REG_ZERO)) begin
        fwd_hit2 = 1'b1;
        fwd_data2 = ent_data[idx];
      end
    end
  end
endmodule
